// File: rtl/irq_pkg.sv
// Types, default addresses and vector helper for the interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    VECTOR = 2'd2,
    DONE   = 2'd3
  } irq_state_e;

  localparam logic [15:0] IRQ_IF_ADDR = 16'hFF0F;
  localparam logic [15:0] IRQ_IE_ADDR = 16'hFFFF;

  localparam int SRC_VBLANK = 0;
  localparam int SRC_LCDC   = 1;
  localparam int SRC_TIMER  = 2;
  localparam int SRC_SERIAL = 3;
  localparam int SRC_JOYPAD = 4;

  // Vector byte for a source; arithmetic wraps modulo 256.
  function automatic logic [7:0] vec_addr(input logic [7:0] base,
                                          input logic [7:0] stride,
                                          input logic [2:0] idx);
    logic [7:0] w_off;
    w_off = stride * {5'd0, idx};
    return base + w_off;
  endfunction

endpackage

// File: rtl/irq_controller_n_prio_enc.sv
// Lowest-index-first priority encoder over the pending vector.
module irq_prio_enc #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller_n.sv
// IF/IE register pair, request capture and TV80 acknowledge sequencer.
//   state  | meaning
//   IDLE   | no enabled request pending, int_n high
//   ARMED  | int_n low, waiting for the m1/iorq acknowledge
//   VECTOR | jump_addr presented and frozen until iorq_n rises
//   DONE   | clear serviced IF bit, pulse int_ack for one cycle
module irq_controller_n
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ    = 5,
  parameter logic [7:0]  EDGE_MASK  = 8'h1F,
  parameter logic [7:0]  VEC_BASE   = 8'h40,
  parameter logic [7:0]  VEC_STRIDE = 8'h08,
  parameter logic [15:0] IF_ADDR    = IRQ_IF_ADDR,
  parameter logic [15:0] IE_ADDR    = IRQ_IE_ADDR
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cs,
  input  logic [15:0]        A,
  input  logic [7:0]         Di,
  output logic [7:0]         Do,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic               m1_n,
  input  logic               iorq_n,
  input  logic [NUM_IRQ-1:0] int_req,
  output logic [NUM_IRQ-1:0] int_ack,
  output logic               int_n,
  output logic [7:0]         jump_addr
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [NUM_IRQ-1:0] EDGE_M = EDGE_MASK[NUM_IRQ-1:0];
  localparam logic [NUM_IRQ-1:0] ONE    = NUM_IRQ'(1);

  logic [NUM_IRQ-1:0] r_if;
  logic [NUM_IRQ-1:0] r_ie;
  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_int_ack;
  logic [IDX_W-1:0]   r_idx;
  logic [7:0]         r_jump;
  logic               r_int_n;
  irq_state_e         r_state;

  logic [NUM_IRQ-1:0] w_set;
  logic [NUM_IRQ-1:0] w_pend;
  logic [NUM_IRQ-1:0] w_if_next;
  logic [IDX_W-1:0]   w_k;
  logic               w_k_valid;
  logic               w_if_wr;
  logic               w_ie_wr;
  logic               w_ack_cyc;
  logic [7:0]         w_if_rd;
  logic [7:0]         w_ie_rd;
  logic               w_unused_di;

  assign w_unused_di = ^Di;
  assign w_set     = (int_req & ~r_prev & EDGE_M) | (int_req & ~EDGE_M);
  assign w_pend    = r_if & r_ie;
  assign w_if_wr   = cs & ~wr_n & (A == IF_ADDR);
  assign w_ie_wr   = cs & ~wr_n & (A == IE_ADDR);
  assign w_ack_cyc = ~m1_n & ~iorq_n;

  irq_prio_enc #(
    .N     (NUM_IRQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .i_req   (w_pend),
    .o_valid (w_k_valid),
    .o_idx   (w_k)
  );

  // Hardware sets are OR-ed last so they win over software and ack clears.
  always_comb begin
    w_if_next = w_if_wr ? Di[NUM_IRQ-1:0] : r_if;
    if (r_state == DONE) w_if_next = w_if_next & ~(ONE << r_idx);
    w_if_next = w_if_next | w_set;
  end

  always_comb begin
    w_if_rd = 8'hFF;
    w_if_rd[NUM_IRQ-1:0] = r_if;
    w_ie_rd = 8'h00;
    w_ie_rd[NUM_IRQ-1:0] = r_ie;
    Do = 8'hFF;
    if (cs && !rd_n) begin
      if (A == IF_ADDR)      Do = w_if_rd;
      else if (A == IE_ADDR) Do = w_ie_rd;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_if   <= '0;
      r_ie   <= '0;
      r_prev <= '0;
    end else begin
      r_if   <= w_if_next;
      r_prev <= int_req;
      if (w_ie_wr) r_ie <= Di[NUM_IRQ-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_int_n   <= 1'b1;
      r_int_ack <= '0;
      r_idx     <= '0;
      r_jump    <= VEC_BASE;
    end else begin
      case (r_state)
        IDLE: begin
          r_int_ack <= '0;
          if (w_k_valid) begin
            r_state <= ARMED;
            r_int_n <= 1'b0;
          end
        end
        ARMED: begin
          if (!w_k_valid) begin
            r_state <= IDLE;
            r_int_n <= 1'b1;
          end else if (w_ack_cyc) begin
            r_idx   <= w_k;
            r_jump  <= vec_addr(VEC_BASE, VEC_STRIDE, 3'(w_k));
            r_state <= VECTOR;
          end
        end
        VECTOR: begin
          if (iorq_n) begin
            r_state   <= DONE;
            r_int_ack <= ONE << r_idx;
            r_int_n   <= 1'b1;
          end
        end
        DONE: begin
          r_int_ack <= '0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign int_ack   = r_int_ack;
  assign int_n     = r_int_n;
  assign jump_addr = r_jump;

endmodule

// File: tb/tb_irq_controller_n.sv
// Scoreboard bench: acks and register reads are checked by monitors against queued expectations.
module tb_irq_controller_n;

  logic        clock = 1'b0;
  logic        rst_ab = 1'b0;
  logic        rst_c = 1'b0;
  logic        cs_a = 1'b0, cs_b = 1'b0, cs_c = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [7:0]  Di = 8'h00;
  logic        rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1, iorq_n = 1'b1;
  logic [4:0]  req_a = '0, req_b = '0;
  logic [7:0]  req_c = '0;

  logic [7:0]  do_a, do_b, do_c, jump_a, jump_b, jump_c;
  logic [4:0]  ack_a, ack_b;
  logic [7:0]  ack_c;
  logic        int_n_a, int_n_b, int_n_c;

  int n_pass = 0;
  int n_total = 0;

  logic [12:0] ackq_a[$];
  logic [15:0] ackq_c[$];
  logic [7:0]  rdq[$];

  always #5 clock = ~clock;

  irq_controller_n dut_a (
    .clock(clock), .reset_n(rst_ab), .cs(cs_a), .A(A), .Di(Di), .Do(do_a),
    .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .iorq_n(iorq_n),
    .int_req(req_a), .int_ack(ack_a), .int_n(int_n_a), .jump_addr(jump_a));

  irq_controller_n #(.EDGE_MASK(8'h1D)) dut_b (
    .clock(clock), .reset_n(rst_ab), .cs(cs_b), .A(A), .Di(Di), .Do(do_b),
    .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .iorq_n(iorq_n),
    .int_req(req_b), .int_ack(ack_b), .int_n(int_n_b), .jump_addr(jump_b));

  irq_controller_n #(.NUM_IRQ(8), .EDGE_MASK(8'hFF), .VEC_STRIDE(8'h20)) dut_c (
    .clock(clock), .reset_n(rst_c), .cs(cs_c), .A(A), .Di(Di), .Do(do_c),
    .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .iorq_n(iorq_n),
    .int_req(req_c), .int_ack(ack_c), .int_n(int_n_c), .jump_addr(jump_c));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sel_cs(input int sel, input logic on);
    cs_a = on && (sel == 0);
    cs_b = on && (sel == 1);
    cs_c = on && (sel == 2);
  endtask

  task automatic wr(input int sel, input logic [15:0] addr, input logic [7:0] data);
    A = addr; Di = data; wr_n = 1'b0; sel_cs(sel, 1'b1);
    tick();
    wr_n = 1'b1; sel_cs(sel, 1'b0);
  endtask

  task automatic rd(input int sel, input logic [15:0] addr, input logic [7:0] exp);
    rdq.push_back(exp);
    A = addr; rd_n = 1'b0; sel_cs(sel, 1'b1);
    tick();
    rd_n = 1'b1; sel_cs(sel, 1'b0);
  endtask

  function automatic logic sel_int_n(input int sel);
    return (sel == 2) ? int_n_c : int_n_a;
  endfunction

  function automatic logic [7:0] sel_jump(input int sel);
    return (sel == 2) ? jump_c : jump_a;
  endfunction

  // Wait for int_n low, run an acknowledge, optionally pulse req_a while in VECTOR.
  task automatic cpu_ack(input int sel, input logic [7:0] exp_jump, input logic [4:0] mid_req);
    int guard = 0;
    while (sel_int_n(sel) && guard < 20) begin tick(); guard++; end
    if (guard == 20) check("armed_timeout", 32'(guard), 32'd0);
    m1_n = 1'b0; iorq_n = 1'b0;
    tick();
    req_a = mid_req;
    tick();
    req_a = '0;
    check("vector_jump", 32'(sel_jump(sel)), 32'(exp_jump));
    check("vector_int_n", 32'(sel_int_n(sel)), 32'd0);
    m1_n = 1'b1; iorq_n = 1'b1;
    tick();
    tick();
  endtask

  always @(negedge clock) begin
    if (ack_a != '0) begin
      if (ackq_a.size() == 0) check("unexpected_ack_a", {19'd0, ack_a, jump_a}, 32'd0);
      else check("ack_a", {19'd0, ack_a, jump_a}, {19'd0, ackq_a.pop_front()});
    end
    if (ack_c != '0) begin
      if (ackq_c.size() == 0) check("unexpected_ack_c", {16'd0, ack_c, jump_c}, 32'd0);
      else check("ack_c", {16'd0, ack_c, jump_c}, {16'd0, ackq_c.pop_front()});
    end
    if (ack_b != '0) check("unexpected_ack_b", 32'(ack_b), 32'd0);
    if (!rd_n && (cs_a || cs_b || cs_c)) begin
      if (rdq.size() == 0) check("unexpected_read", 32'(do_a), 32'd0);
      else check("read", cs_a ? 32'(do_a) : cs_b ? 32'(do_b) : 32'(do_c), 32'(rdq.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_int_n", 32'(int_n_a), 32'd1);
    check("rst_int_ack", 32'(ack_a), 32'd0);
    check("rst_jump", 32'(jump_a), 32'h40);
    check("rst_do", 32'(do_a), 32'hFF);
    #10;
    rst_ab = 1'b1; rst_c = 1'b1;
    tick();
    rd(0, 16'hFF0F, 8'hE0);
    rd(0, 16'hFFFF, 8'h00);

    // 1: single edge request on source 2
    wr(0, 16'hFFFF, 8'h1F);
    rd(0, 16'hFFFF, 8'h1F);
    req_a = 5'b00100;
    tick();
    req_a = '0;
    check("t1_int_n_after1", 32'(int_n_a), 32'd1);
    tick();
    check("t1_int_n_after2", 32'(int_n_a), 32'd0);
    rd(0, 16'hFF0F, 8'hE4);
    ackq_a.push_back({5'b00100, 8'h50});
    cpu_ack(0, 8'h50, 5'b0);
    rd(0, 16'hFF0F, 8'hE0);

    // 2: simultaneous sources 0 and 4, lowest index first
    wr(0, 16'hFFFF, 8'h11);
    req_a = 5'b10001;
    tick();
    req_a = '0;
    ackq_a.push_back({5'b00001, 8'h40});
    ackq_a.push_back({5'b10000, 8'h60});
    cpu_ack(0, 8'h40, 5'b0);
    cpu_ack(0, 8'h60, 5'b0);
    rd(0, 16'hFF0F, 8'hE0);

    // 3: IE gating and software withdrawal while ARMED
    wr(0, 16'hFFFF, 8'h00);
    wr(0, 16'hFF0F, 8'h01);
    tick(); tick();
    check("t3_ie0_int_n", 32'(int_n_a), 32'd1);
    wr(0, 16'hFFFF, 8'h01);
    tick();
    check("t3_armed_int_n", 32'(int_n_a), 32'd0);
    wr(0, 16'hFF0F, 8'h00);
    tick();
    check("t3_withdrawn_int_n", 32'(int_n_a), 32'd1);
    tick(); tick();
    rd(0, 16'hFF0F, 8'hE0);

    // 4: later higher-priority request does not disturb the latched index
    wr(0, 16'hFFFF, 8'h1F);
    req_a = 5'b01000;
    tick();
    req_a = '0;
    ackq_a.push_back({5'b01000, 8'h58});
    cpu_ack(0, 8'h58, 5'b00001);
    rd(0, 16'hFF0F, 8'hE1);
    ackq_a.push_back({5'b00001, 8'h40});
    cpu_ack(0, 8'h40, 5'b0);
    rd(0, 16'hFF0F, 8'hE0);

    // 5: level source beats a software clear in the same cycle
    req_b = 5'b00010;
    tick();
    wr(1, 16'hFF0F, 8'h00);
    rd(1, 16'hFF0F, 8'hE2);
    req_b = '0;
    wr(1, 16'hFF0F, 8'h00);
    rd(1, 16'hFF0F, 8'hE0);
    check("t5_int_n_b", 32'(int_n_b), 32'd1);

    // 6: eight sources, wrapping vector, reset during VECTOR
    wr(2, 16'hFFFF, 8'h80);
    req_c = 8'h80;
    tick();
    req_c = '0;
    ackq_c.push_back({8'h80, 8'h20});
    cpu_ack(2, 8'h20, 5'b0);
    rd(2, 16'hFF0F, 8'h00);
    req_c = 8'h80;
    tick();
    req_c = '0;
    tick();
    check("t6_armed_int_n", 32'(int_n_c), 32'd0);
    m1_n = 1'b0; iorq_n = 1'b0;
    tick(); tick();
    check("t6_vector_jump", 32'(jump_c), 32'h20);
    rst_c = 1'b0;
    #1;
    check("t6_rst_int_n", 32'(int_n_c), 32'd1);
    check("t6_rst_jump", 32'(jump_c), 32'h40);
    tick();
    rst_c = 1'b1;
    m1_n = 1'b1; iorq_n = 1'b1;
    tick(); tick(); tick();
    rd(2, 16'hFF0F, 8'h00);
    rd(2, 16'hFFFF, 8'h00);
    check("t6_int_n_idle", 32'(int_n_c), 32'd1);

    tick(); tick();
    check("ackq_a_left", 32'(ackq_a.size()), 32'd0);
    check("ackq_c_left", 32'(ackq_c.size()), 32'd0);
    check("rdq_left", 32'(rdq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
